// File: rtl/axi_lite_arbiter_pkg.sv
// Shared types for the two-master AXI-Lite arbiter.
//   axi_mst_resp_t : AXI response code (OKAY/EXOKAY/SLVERR/DECERR)
//   arb_state_e    : one-hot arbiter state
//   grant_e        : identity of the last granted master (round-robin build only)
//   AxiAddrW/AxiDataW : default bus widths, matching the core's AXI address/data buses
package axi_lite_arbiter_pkg;

   localparam int unsigned AxiAddrW = 32;
   localparam int unsigned AxiDataW = 32;

   typedef enum logic [1:0] {
      RespOkay   = 2'd0,
      RespExokay = 2'd1,
      RespSlverr = 2'd2,
      RespDecerr = 2'd3
   } axi_mst_resp_t;

   typedef enum logic [3:0] {
      StIdle     = 4'b0001,
      StGntIfuRd = 4'b0010,
      StGntLsuRd = 4'b0100,
      StGntLsuWr = 4'b1000
   } arb_state_e;

   typedef enum logic {
      GntIfu = 1'b0,
      GntLsu = 1'b1
   } grant_e;

endpackage

// File: rtl/axi_lite_arbiter_if.sv
// AXI-Lite bus bundle.
//   master    : full AXI-Lite master side (drives AR/AW/W valids, R/B ready)
//   slave     : full AXI-Lite slave side
//   rd_master : read-only master (AR/R channels), e.g. the IFU
//   rd_slave  : read-only slave view of a read-only master
interface axi_lite_arbiter_if
   import axi_lite_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = AxiAddrW,
   parameter int unsigned DATA_W = AxiDataW
);

   logic                  ar_valid;
   logic [ADDR_W-1:0]     ar_addr;
   logic                  ar_ready;
   logic                  r_valid;
   logic [DATA_W-1:0]     r_data;
   axi_mst_resp_t         r_resp;
   logic                  r_ready;
   logic                  aw_valid;
   logic [ADDR_W-1:0]     aw_addr;
   logic                  aw_ready;
   logic                  w_valid;
   logic [DATA_W-1:0]     w_data;
   logic [DATA_W/8-1:0]   w_strb;
   logic                  w_ready;
   logic                  b_valid;
   axi_mst_resp_t         b_resp;
   logic                  b_ready;

   modport master (
      output ar_valid, ar_addr, r_ready, aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
      input  ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
   );

   modport slave (
      input  ar_valid, ar_addr, r_ready, aw_valid, aw_addr, w_valid, w_data, w_strb, b_ready,
      output ar_ready, r_valid, r_data, r_resp, aw_ready, w_ready, b_valid, b_resp
   );

   modport rd_master (
      output ar_valid, ar_addr, r_ready,
      input  ar_ready, r_valid, r_data, r_resp
   );

   modport rd_slave (
      input  ar_valid, ar_addr, r_ready,
      output ar_ready, r_valid, r_data, r_resp
   );

endinterface

// File: rtl/axi_lite_arbiter.sv
// Two-master to one-slave AXI-Lite arbiter. One whole transaction is granted at a
// time (AR->R or AW->W->B); no overlap, no reordering.
//   clk_i : clock
//   rst_i : asynchronous active-low reset
//   ifu   : IFU read-only master (AR/R)
//   lsu   : LSU full AXI-Lite master
//   slv   : downstream memory/SoC AXI-Lite slave
// Optional: define YSYX_23060251_ARB_RR_EN for round-robin between IFU and LSU;
// otherwise fixed priority LSU read > LSU write > IFU read.
module axi_lite_arbiter
   import axi_lite_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = AxiAddrW,
   parameter int unsigned DATA_W = AxiDataW
) (
   input logic                 clk_i,
   input logic                 rst_i,
   axi_lite_arbiter_if.rd_slave ifu,
   axi_lite_arbiter_if.slave    lsu,
   axi_lite_arbiter_if.master   slv
);

   arb_state_e state;

`ifdef YSYX_23060251_ARB_RR_EN
   grant_e last_grant;
   logic   lsu_req;
   assign lsu_req = lsu.ar_valid | lsu.aw_valid;
`endif

   // Grant decisions are taken only in idle; a grant lasts until the closing
   // response handshake, so a release and a new request always cost one idle cycle.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state      <= StIdle;
`ifdef YSYX_23060251_ARB_RR_EN
         last_grant <= GntIfu;
`endif
      end else begin
         unique case (state)
            StIdle: begin
`ifdef YSYX_23060251_ARB_RR_EN
               // On contention the master not granted last wins; LSU read still
               // beats LSU write.
               if (lsu_req && (!ifu.ar_valid || last_grant == GntIfu)) begin
                  state      <= lsu.ar_valid ? StGntLsuRd : StGntLsuWr;
                  last_grant <= GntLsu;
               end else if (ifu.ar_valid) begin
                  state      <= StGntIfuRd;
                  last_grant <= GntIfu;
               end
`else
               if (lsu.ar_valid) begin
                  state <= StGntLsuRd;
               end else if (lsu.aw_valid) begin
                  state <= StGntLsuWr;
               end else if (ifu.ar_valid) begin
                  state <= StGntIfuRd;
               end
`endif
            end
            StGntIfuRd, StGntLsuRd: begin
               if (slv.r_valid && slv.r_ready) state <= StIdle;
            end
            StGntLsuWr: begin
               if (slv.b_valid && slv.b_ready) state <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

   // Pure pass-through of the granted master; everything else held at zero.
   always_comb begin
      ifu.ar_ready = 1'b0;
      ifu.r_valid  = 1'b0;
      ifu.r_data   = {DATA_W{1'b0}};
      ifu.r_resp   = RespOkay;
      lsu.ar_ready = 1'b0;
      lsu.r_valid  = 1'b0;
      lsu.r_data   = {DATA_W{1'b0}};
      lsu.r_resp   = RespOkay;
      lsu.aw_ready = 1'b0;
      lsu.w_ready  = 1'b0;
      lsu.b_valid  = 1'b0;
      lsu.b_resp   = RespOkay;
      slv.ar_valid = 1'b0;
      slv.ar_addr  = {ADDR_W{1'b0}};
      slv.r_ready  = 1'b0;
      slv.aw_valid = 1'b0;
      slv.aw_addr  = {ADDR_W{1'b0}};
      slv.w_valid  = 1'b0;
      slv.w_data   = {DATA_W{1'b0}};
      slv.w_strb   = {(DATA_W/8){1'b0}};
      slv.b_ready  = 1'b0;
      unique case (state)
         StGntIfuRd: begin
            slv.ar_valid = ifu.ar_valid;
            slv.ar_addr  = ifu.ar_addr;
            ifu.ar_ready = slv.ar_ready;
            ifu.r_valid  = slv.r_valid;
            ifu.r_data   = slv.r_data;
            ifu.r_resp   = slv.r_resp;
            slv.r_ready  = ifu.r_ready;
         end
         StGntLsuRd: begin
            slv.ar_valid = lsu.ar_valid;
            slv.ar_addr  = lsu.ar_addr;
            lsu.ar_ready = slv.ar_ready;
            lsu.r_valid  = slv.r_valid;
            lsu.r_data   = slv.r_data;
            lsu.r_resp   = slv.r_resp;
            slv.r_ready  = lsu.r_ready;
         end
         StGntLsuWr: begin
            slv.aw_valid = lsu.aw_valid;
            slv.aw_addr  = lsu.aw_addr;
            lsu.aw_ready = slv.aw_ready;
            slv.w_valid  = lsu.w_valid;
            slv.w_data   = lsu.w_data;
            slv.w_strb   = lsu.w_strb;
            lsu.w_ready  = slv.w_ready;
            lsu.b_valid  = slv.b_valid;
            lsu.b_resp   = slv.b_resp;
            slv.b_ready  = lsu.b_ready;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed self-checking bench for axi_lite_arbiter.
module tb_axi_lite_arbiter;
   import axi_lite_arbiter_pkg::*;

   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] exp_addr;

   axi_lite_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifu_bus ();
   axi_lite_arbiter_if #(.ADDR_W(32), .DATA_W(32)) lsu_bus ();
   axi_lite_arbiter_if #(.ADDR_W(32), .DATA_W(32)) slv_bus ();

   axi_lite_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .ifu   (ifu_bus),
      .lsu   (lsu_bus),
      .slv   (slv_bus)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      ifu_bus.ar_valid = 1'b0; ifu_bus.ar_addr = '0; ifu_bus.r_ready = 1'b0;
      ifu_bus.aw_valid = 1'b0; ifu_bus.aw_addr = '0; ifu_bus.w_valid = 1'b0;
      ifu_bus.w_data = '0; ifu_bus.w_strb = '0; ifu_bus.b_ready = 1'b0;
      ifu_bus.aw_ready = 1'b0; ifu_bus.w_ready = 1'b0; ifu_bus.b_valid = 1'b0;
      ifu_bus.b_resp = RespOkay;
      lsu_bus.ar_valid = 1'b0; lsu_bus.ar_addr = '0; lsu_bus.r_ready = 1'b0;
      lsu_bus.aw_valid = 1'b0; lsu_bus.aw_addr = '0; lsu_bus.w_valid = 1'b0;
      lsu_bus.w_data = '0; lsu_bus.w_strb = '0; lsu_bus.b_ready = 1'b0;
      slv_bus.ar_ready = 1'b0; slv_bus.r_valid = 1'b0; slv_bus.r_data = '0;
      slv_bus.r_resp = RespOkay; slv_bus.aw_ready = 1'b0; slv_bus.w_ready = 1'b0;
      slv_bus.b_valid = 1'b0; slv_bus.b_resp = RespOkay;

      // Reset state
      step(); step();
      chk_bit("rst_slv_ar_valid", slv_bus.ar_valid, 1'b0);
      chk_bit("rst_slv_aw_valid", slv_bus.aw_valid, 1'b0);
      chk_bit("rst_lsu_ar_ready", lsu_bus.ar_ready, 1'b0);
      chk_bit("rst_ifu_r_valid", ifu_bus.r_valid, 1'b0);
      rst_i = 1'b1;

      // IFU-only read
      ifu_bus.ar_valid = 1'b1; ifu_bus.ar_addr = 32'h8000_0000; ifu_bus.r_ready = 1'b1;
      #1;
      chk_bit("ifu_idle_no_ar", slv_bus.ar_valid, 1'b0);
      step();
      chk_bit("ifu_slv_ar_valid", slv_bus.ar_valid, 1'b1);
      chk_word("ifu_slv_ar_addr", slv_bus.ar_addr, 32'h8000_0000);
      chk_bit("ifu_ar_ready_lo", ifu_bus.ar_ready, 1'b0);
      slv_bus.ar_ready = 1'b1;
      #1;
      chk_bit("ifu_ar_ready_hi", ifu_bus.ar_ready, 1'b1);
      step();
      ifu_bus.ar_valid = 1'b0; slv_bus.ar_ready = 1'b0;
      slv_bus.r_valid = 1'b1; slv_bus.r_data = 32'h0000_0413; slv_bus.r_resp = RespOkay;
      #1;
      chk_bit("ifu_slv_r_ready", slv_bus.r_ready, 1'b1);
      chk_bit("ifu_r_valid", ifu_bus.r_valid, 1'b1);
      chk_word("ifu_r_data", ifu_bus.r_data, 32'h0000_0413);
      chk_word("ifu_r_resp", 32'(ifu_bus.r_resp), 32'd0);
      step();
      // Back in idle: a still-pending slave r_valid must not be accepted
      chk_bit("idle_r_not_acc", slv_bus.r_ready, 1'b0);
      chk_bit("idle_ifu_r_valid", ifu_bus.r_valid, 1'b0);
      slv_bus.r_valid = 1'b0;

      // Contention: LSU read wins, slave returns SLVERR, then IFU after one bubble
      ifu_bus.ar_valid = 1'b1; ifu_bus.ar_addr = 32'h8000_0100;
      lsu_bus.ar_valid = 1'b1; lsu_bus.ar_addr = 32'h8000_2000; lsu_bus.r_ready = 1'b1;
      step();
      slv_bus.ar_ready = 1'b1;
      #1;
      chk_word("cont1_slv_ar_addr", slv_bus.ar_addr, 32'h8000_2000);
      chk_bit("cont1_lsu_ar_ready", lsu_bus.ar_ready, 1'b1);
      chk_bit("cont1_ifu_ar_ready", ifu_bus.ar_ready, 1'b0);
      step();
      lsu_bus.ar_valid = 1'b0; slv_bus.ar_ready = 1'b0;
      slv_bus.r_valid = 1'b1; slv_bus.r_data = 32'h1111_2222; slv_bus.r_resp = RespSlverr;
      #1;
      chk_word("slverr_lsu_r_resp", 32'(lsu_bus.r_resp), 32'd2);
      chk_word("slverr_lsu_r_data", lsu_bus.r_data, 32'h1111_2222);
      chk_bit("slverr_ifu_r_valid", ifu_bus.r_valid, 1'b0);
      step();
      slv_bus.r_valid = 1'b0; slv_bus.r_resp = RespOkay;
      #1;
      chk_bit("cont1_bubble", slv_bus.ar_valid, 1'b0);
      step();
      chk_bit("cont1_ifu_gnt", slv_bus.ar_valid, 1'b1);
      chk_word("cont1_ifu_addr", slv_bus.ar_addr, 32'h8000_0100);
      slv_bus.ar_ready = 1'b1;
      step();
      ifu_bus.ar_valid = 1'b0; slv_bus.ar_ready = 1'b0;
      slv_bus.r_valid = 1'b1; slv_bus.r_data = 32'h0000_0013;
      step();
      slv_bus.r_valid = 1'b0;

      // LSU store
      lsu_bus.aw_valid = 1'b1; lsu_bus.aw_addr = 32'h8000_1000;
      lsu_bus.w_valid = 1'b1; lsu_bus.w_data = 32'hDEAD_BEEF; lsu_bus.w_strb = 4'hF;
      lsu_bus.b_ready = 1'b1;
      step();
      chk_bit("st_slv_aw_valid", slv_bus.aw_valid, 1'b1);
      chk_word("st_slv_aw_addr", slv_bus.aw_addr, 32'h8000_1000);
      chk_word("st_slv_w_data", slv_bus.w_data, 32'hDEAD_BEEF);
      chk_word("st_slv_w_strb", 32'(slv_bus.w_strb), 32'hF);
      chk_bit("st_lsu_b_valid_pre", lsu_bus.b_valid, 1'b0);
      slv_bus.aw_ready = 1'b1; slv_bus.w_ready = 1'b1;
      #1;
      chk_bit("st_lsu_aw_ready", lsu_bus.aw_ready, 1'b1);
      chk_bit("st_lsu_w_ready", lsu_bus.w_ready, 1'b1);
      step();
      lsu_bus.aw_valid = 1'b0; lsu_bus.w_valid = 1'b0;
      slv_bus.aw_ready = 1'b0; slv_bus.w_ready = 1'b0;
      slv_bus.b_valid = 1'b1; slv_bus.b_resp = RespOkay;
      #1;
      chk_bit("st_lsu_b_valid", lsu_bus.b_valid, 1'b1);
      chk_bit("st_slv_b_ready", slv_bus.b_ready, 1'b1);
      step();
      chk_bit("st_b_one_cycle", lsu_bus.b_valid, 1'b0);
      slv_bus.b_valid = 1'b0;

      // Second collision: last grant was the LSU
      ifu_bus.ar_valid = 1'b1; ifu_bus.ar_addr = 32'h8000_0200;
      lsu_bus.ar_valid = 1'b1; lsu_bus.ar_addr = 32'h8000_4000;
`ifdef YSYX_23060251_ARB_RR_EN
      exp_addr = 32'h8000_0200;
`else
      exp_addr = 32'h8000_4000;
`endif
      step();
      chk_word("cont2_slv_ar_addr", slv_bus.ar_addr, exp_addr);
      slv_bus.ar_ready = 1'b1;
      step();
      ifu_bus.ar_valid = 1'b0; lsu_bus.ar_valid = 1'b0; slv_bus.ar_ready = 1'b0;
      slv_bus.r_valid = 1'b1;
      step();
      slv_bus.r_valid = 1'b0;

      // Back-to-back LSU reads: one idle bubble, then the new address
      lsu_bus.ar_valid = 1'b1; lsu_bus.ar_addr = 32'h8000_3000;
      step();
      slv_bus.ar_ready = 1'b1;
      step();
      slv_bus.ar_ready = 1'b0; lsu_bus.ar_addr = 32'h8000_3004;
      slv_bus.r_valid = 1'b1;
      step();
      slv_bus.r_valid = 1'b0;
      #1;
      chk_bit("b2b_bubble", slv_bus.ar_valid, 1'b0);
      step();
      chk_bit("b2b_slv_ar_valid", slv_bus.ar_valid, 1'b1);
      chk_word("b2b_slv_ar_addr", slv_bus.ar_addr, 32'h8000_3004);
      slv_bus.ar_ready = 1'b1;
      step();
      lsu_bus.ar_valid = 1'b0; slv_bus.ar_ready = 1'b0; slv_bus.r_valid = 1'b1;
      step();
      slv_bus.r_valid = 1'b0;

      // Async reset mid-write, after the AW handshake
      lsu_bus.aw_valid = 1'b1; lsu_bus.aw_addr = 32'h8000_5000;
      step();
      slv_bus.aw_ready = 1'b1;
      step();
      lsu_bus.aw_valid = 1'b0; slv_bus.aw_ready = 1'b0;
      lsu_bus.w_valid = 1'b1; lsu_bus.w_data = 32'h1234_5678; slv_bus.w_ready = 1'b1;
      #1;
      chk_bit("arst_pre_w_valid", slv_bus.w_valid, 1'b1);
      #1;
      rst_i = 1'b0;
      #1;
      chk_bit("arst_slv_w_valid", slv_bus.w_valid, 1'b0);
      chk_bit("arst_lsu_w_ready", lsu_bus.w_ready, 1'b0);
      chk_bit("arst_slv_b_ready", slv_bus.b_ready, 1'b0);
      step();
      rst_i = 1'b1;
      step();
      // A leftover W beat with no AW request must not be forwarded from idle
      chk_bit("arst_no_stale_w", slv_bus.w_valid, 1'b0);
      chk_bit("arst_no_stale_aw", slv_bus.aw_valid, 1'b0);
      lsu_bus.w_valid = 1'b0; slv_bus.w_ready = 1'b0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi_lite_arbiter.md
Name: axi_lite_arbiter

Overview:
- Two-master-to-one-slave AXI-Lite arbiter. It sits directly downstream of the LSU AXI master port and the IFU read port, and drives the single memory/SoC AXI-Lite slave.
- It grants one whole transaction at a time: AR→R for reads, AW→W→B for writes.
- No reordering and no outstanding-transaction overlap, which keeps the IFU/LSU FSMs valid.

Parameters:
- ADDR_W, 32, AXI address width (matches `ysyx_23060251_axi_addr_bus).
- DATA_W, 32, AXI data width (matches `ysyx_23060251_axi_data_bus).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-low reset (asserted when 0)
- ifu_ar_valid_i  in  1  IFU read-address valid
- ifu_ar_addr_i  in  ADDR_W  IFU read address
- ifu_ar_ready_o  out  1  IFU read-address ready
- ifu_r_valid_o  out  1  IFU read-data valid
- ifu_r_data_o  out  DATA_W  IFU read data
- ifu_r_resp_o  out  axi_mst_resp_t  IFU read response
- ifu_r_ready_i  in  1  IFU read-data ready
- lsu_ar_*, lsu_r_*, lsu_aw_*, lsu_w_* (data, strb DATA_W/8), lsu_b_*: full AXI-Lite slave side facing the LSU master, same signal set as the LSU master port.
- slv_ar_*, slv_r_*, slv_aw_*, slv_w_*, slv_b_*: full AXI-Lite master side toward memory.

Behaviour:
- States, one-hot: IDLE, GNT_IFU_RD, GNT_LSU_RD, GNT_LSU_WR.
- Reset (rst_i=0, asynchronous):
  - state=IDLE.
  - All *_valid_o / *_ready_o outputs = 0.
  - Data/addr outputs are don't-care; driving them to 0 is recommended.
- In IDLE, no channel is forwarded:
  - slv valids = 0; all master-side readies and valids = 0.
  - A slave r_valid/b_valid arriving in IDLE is not accepted. It stays pending and is not a protocol error for this block.
- Arbitration happens in IDLE on the registered clock edge. Requests are lsu_ar_valid, lsu_aw_valid and ifu_ar_valid. Fixed priority: LSU read > LSU write > IFU read.
- Arbitration latency: the request is sampled in IDLE, the grant state is entered next cycle, and slv_*_valid rises that cycle. Minimum cost is 1 cycle of added latency per transaction.
- GNT_IFU_RD:
  - AR and R channels pass through combinationally between ifu_* and slv_*.
  - LSU readies are held at 0.
  - Exit to IDLE on slv R handshake (slv_r_valid & slv_r_ready).
- GNT_LSU_RD: same as GNT_IFU_RD, with LSU as the master. Exit on the R handshake.
- GNT_LSU_WR:
  - AW, W and B pass through combinationally.
  - The LSU issues AW then W sequentially; the arbiter does not enforce ordering beyond pass-through.
  - Exit to IDLE on slv B handshake.
- Handshake passthrough: each valid/ready and its payload are forwarded unchanged. The arbiter never generates a handshake on its own.
- Boundary conditions:
  - A release handshake and a new request in the same cycle: state returns to IDLE, then the new grant follows the cycle after. This gives one bubble, deliberately.
  - lsu_ar_valid and lsu_aw_valid both high in IDLE: the read is granted first; the write waits.
  - A master dropping valid before its handshake is illegal for AXI. The arbiter stays in the grant state regardless.
  - Reset asserted mid-transaction: immediately returns to IDLE with outputs 0. The in-flight slave transaction is abandoned and the slave must be reset together with the arbiter.
  - slv_r_resp / slv_b_resp are forwarded unmodified, including SLVERR and DECERR.

Optional Feature:
- Macro: YSYX_23060251_ARB_RR_EN.
- Defined: round-robin between IFU and LSU, using a 1-bit last_grant register (reset = IFU).
  - When both request, the master not granted last wins.
  - LSU read vs LSU write priority is unchanged.
- Undefined: fixed priority as specified in Behaviour, and the last_grant register is not present.

Decomposition:
- Shared package:
  - axi_mst_resp_t (2-bit: OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3).
  - Arbiter state localparams or enum.
  - Width macros reused from the existing ysyx_23060251 defines.
- Single module with no sub-module. The passthrough mux is one always_comb keyed on state.

Test Plan:
- IFU only: ifu_ar_valid=1, addr 0x8000_0000; slave ar_ready=1 at cycle 2 and r_valid with data 0x0000_0413 at cycle 4 → slv_ar_valid rises 1 cycle after the request, ifu_r_data_o=0x0000_0413, resp OKAY, state back to IDLE the cycle after r_hs.
- LSU store: aw addr 0x8000_1000, w data 0xDEAD_BEEF, strb 0xF; slave b_valid with resp OKAY → slv_w_strb=0xF, lsu_b_valid_o=1 exactly one cycle, then IDLE.
- Contention: ifu_ar_valid and lsu_ar_valid both high in IDLE.
  - Without the macro: LSU is granted, then IFU after LSU r_hs plus 1 bubble.
  - With YSYX_23060251_ARB_RR_EN: a second collision is granted to IFU.
- Slave error: slave returns r_resp=SLVERR (2) on an LSU load → lsu_r_resp_o=2, data forwarded, arbiter releases normally.
- Async reset mid-write: rst_i=0 during GNT_LSU_WR after aw_hs → all valid/ready outputs 0 in the same cycle with no clock edge needed; after release, IDLE and no stale grant.
- Back-to-back: a new lsu_ar_valid held high through the previous r_hs → exactly one IDLE bubble, then slv_ar_valid=1 with the new address.
